// File: rtl/eth_pkg.sv
// Shared types and constants for the MII UDP payload receiver.
// Header offsets are byte indices counted from the first byte after the SFD.
package eth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_DRAIN
  } state_t;

  localparam logic [3:0]  PRE_NIB        = 4'h5;
  localparam logic [3:0]  SFD_NIB        = 4'hD;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_VER_IHL     = 8'h45;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;

  localparam logic [5:0] OFF_ETHERTYPE = 6'd12;
  localparam logic [5:0] OFF_VER_IHL   = 6'd14;
  localparam logic [5:0] OFF_PROTO     = 6'd23;
  localparam logic [5:0] OFF_DST_PORT  = 6'd36;
  localparam logic [5:0] OFF_UDP_LEN   = 6'd38;
  localparam logic [5:0] HDR_LEN       = 6'd42;

endpackage

// File: rtl/mii_nibble_to_byte.sv
// Pairs MII nibbles into bytes (low nibble first); phase realigns on SFD.
// Combinational byte strobe on the high-nibble cycle; no backpressure (MII cannot stall).
module mii_nibble_to_byte (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       align,
  input  logic       en,
  input  logic       rx_dv,
  input  logic [3:0] rxd,
  output logic       byte_vld,
  output logic [7:0] byte_dat
);

  logic       phase;
  logic [3:0] lo_nib;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase  <= 1'b0;
      lo_nib <= 4'h0;
    end else if (align || !en) begin
      phase  <= 1'b0;
    end else if (rx_dv) begin
      phase <= ~phase;
      if (!phase) lo_nib <= rxd;
    end
  end

  assign byte_vld = en && rx_dv && phase;
  assign byte_dat = {rxd, lo_nib};

endmodule

// File: rtl/mii_udp_payload_rx.sv
// MII receiver: filters IPv4/UDP by destination port and packs payload into 32-bit RAM words.
// Write lands 1 clk after the completing nibble; no backpressure, excess payload is dropped.
module mii_udp_payload_rx
  import eth_pkg::*;
#(
  parameter logic [15:0]       UDP_PORT  = 16'd5000,
  parameter int                ADDR_W    = 9,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                MAX_WORDS = 375
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              rx_dv,
  input  logic [3:0]        rxd,
  input  logic              rx_err,
  output logic              wr_ena,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err,
  output logic              frame_drop,
  output logic              overflow,
  output logic [ADDR_W-1:0] word_count
);

  localparam logic [ADDR_W-1:0] MAX_CNT = ADDR_W'(MAX_WORDS);

  state_t      state, state_nxt;
  logic        byte_vld;
  logic [7:0]  byte_dat;
  logic [5:0]  byte_idx;
  logic [15:0] udp_len;
  logic [15:0] rem;
  logic [1:0]  lane;
  logic [31:0] acc;
  logic [31:0] word_nxt;
  logic        sfd, hdr_byte, pay_byte, hdr_mismatch, hdr_bad, hdr_last;
  logic        pay_last, word_end, abort_err, abort_dv;

  mii_nibble_to_byte u_nib (
    .clk      (clk),
    .rst_n    (rst_n),
    .align    (sfd),
    .en       (busy),
    .rx_dv    (rx_dv),
    .rxd      (rxd),
    .byte_vld (byte_vld),
    .byte_dat (byte_dat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:
        if (rx_dv) state_nxt = (arm && rxd == PRE_NIB) ? ST_PREAMBLE : ST_DRAIN;
      ST_PREAMBLE:
        if (!rx_dv)              state_nxt = ST_IDLE;
        else if (rxd == SFD_NIB) state_nxt = ST_HEADER;
        else if (rxd != PRE_NIB) state_nxt = ST_DRAIN;
      ST_HEADER:
        if (abort_err)     state_nxt = ST_DRAIN;
        else if (abort_dv) state_nxt = ST_IDLE;
        else if (hdr_bad)  state_nxt = ST_DRAIN;
        else if (hdr_last) state_nxt = (udp_len == 16'd8) ? ST_DRAIN : ST_PAYLOAD;
      ST_PAYLOAD:
        if (abort_err)     state_nxt = ST_DRAIN;
        else if (abort_dv) state_nxt = ST_IDLE;
        else if (pay_last) state_nxt = ST_DRAIN;
      ST_DRAIN:
        if (!rx_dv) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    hdr_mismatch = 1'b0;
    case (byte_idx)
      OFF_ETHERTYPE:         hdr_mismatch = (byte_dat != ETHERTYPE_IPV4[15:8]);
      OFF_ETHERTYPE + 6'd1:  hdr_mismatch = (byte_dat != ETHERTYPE_IPV4[7:0]);
      OFF_VER_IHL:           hdr_mismatch = (byte_dat != IP_VER_IHL);
      OFF_PROTO:             hdr_mismatch = (byte_dat != IP_PROTO_UDP);
      OFF_DST_PORT:          hdr_mismatch = (byte_dat != UDP_PORT[15:8]);
      OFF_DST_PORT + 6'd1:   hdr_mismatch = (byte_dat != UDP_PORT[7:0]);
      OFF_UDP_LEN + 6'd1:    hdr_mismatch = ({udp_len[15:8], byte_dat} < 16'd8);
      default:               hdr_mismatch = 1'b0;
    endcase
  end

  always_comb begin
    sfd       = 1'b0;
    hdr_byte  = 1'b0;
    pay_byte  = 1'b0;
    hdr_bad   = 1'b0;
    hdr_last  = 1'b0;
    pay_last  = 1'b0;
    word_end  = 1'b0;
    abort_err = 1'b0;
    abort_dv  = 1'b0;
    busy      = (state == ST_HEADER) || (state == ST_PAYLOAD);
    case (state)
      ST_PREAMBLE: sfd = rx_dv && (rxd == SFD_NIB);
      ST_HEADER, ST_PAYLOAD: begin
        if (rx_err)       abort_err = 1'b1;
        else if (!rx_dv)  abort_dv  = 1'b1;
        else if (byte_vld) begin
          if (state == ST_HEADER) begin
            hdr_byte = 1'b1;
            hdr_bad  = hdr_mismatch;
            hdr_last = (byte_idx == HDR_LEN - 6'd1);
          end else begin
            pay_byte = 1'b1;
            pay_last = (rem == 16'd1);
            word_end = (lane == 2'd3) || pay_last;
          end
        end
      end
      default: ;
    endcase
  end

  // Lane 0 starts a fresh word so a short final word is zero-padded.
  assign word_nxt = (lane == 2'd0) ? {24'h0, byte_dat}
                                   : acc | ({24'h0, byte_dat} << {lane, 3'b000});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ena     <= 1'b0;
      wr_addr    <= BASE_ADDR;
      wr_data    <= 32'h0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      frame_drop <= 1'b0;
      overflow   <= 1'b0;
      word_count <= '0;
      byte_idx   <= 6'd0;
      udp_len    <= 16'h0;
      rem        <= 16'h0;
      lane       <= 2'd0;
      acc        <= 32'h0;
    end else begin
      wr_ena     <= 1'b0;
      frame_done <= (hdr_last && udp_len == 16'd8) || pay_last;
      frame_err  <= abort_err || abort_dv;
      frame_drop <= hdr_bad;
      if (wr_ena) wr_addr <= wr_addr + ADDR_W'(1);
      if (sfd) begin
        wr_addr    <= BASE_ADDR;
        word_count <= '0;
        overflow   <= 1'b0;
        byte_idx   <= 6'd0;
      end
      if (hdr_byte) begin
        byte_idx <= byte_idx + 6'd1;
        if (byte_idx == OFF_UDP_LEN)        udp_len[15:8] <= byte_dat;
        if (byte_idx == OFF_UDP_LEN + 6'd1) udp_len[7:0]  <= byte_dat;
      end
      if (hdr_last) begin
        rem  <= udp_len - 16'd8;
        lane <= 2'd0;
      end
      if (pay_byte) begin
        rem  <= rem - 16'd1;
        lane <= lane + 2'd1;
        acc  <= word_nxt;
      end
      // Once the RAM window is full, keep parsing but stop writing.
      if (word_end) begin
        if (word_count == MAX_CNT) begin
          overflow <= 1'b1;
        end else begin
          wr_ena     <= 1'b1;
          wr_data    <= word_nxt;
          word_count <= word_count + ADDR_W'(1);
        end
      end
    end
  end

endmodule
